sccb_write_master: RTL and testbench
====================================

Name: sccb_write_master

Overview:
Serialises one OV5640 register write per command into an SCCB (I2C-compatible) 3-phase write.
- Command comes from the HPS register/FIFO stage: start pulse, 16-bit register address, 8-bit data.
- Frame on the wire: device ID, address high byte, address low byte, data byte.
- Sits between the h2f register block and the open-drain camera control pins. It provides the ready handshake that paces the command FIFO.

Parameters:
CLK_FREQ_HZ, 50_000_000, clk_sys frequency
SCL_FREQ_HZ, 100_000, SCL rate
DEV_ADDR, 8'h78, SCCB write ID (R/W bit = 0)
QTR_DIV, CLK_FREQ_HZ/(4*SCL_FREQ_HZ), clk_sys cycles per SCL quarter period; must be >= 2

Ports:
clk_sys      in   1   system clock
reset_n      in   1   asynchronous, active-low reset
start        in   1   one-cycle command strobe; address/data valid in the same cycle
address      in   16  OV5640 register address
data         in   8   register value
ready        out  1   high = a start is accepted now
done         out  1   one-cycle pulse at end of bus-free gap
nack         out  1   registered; valid with done; 1 if any of the 4 ninth bits sampled high
sccb_scl_oe  out  1   1 = drive SCL low, 0 = release
sccb_sda_oe  out  1   1 = drive SDA low, 0 = release
sccb_sda_in  in   1   synchronised (2-flop inside block) SDA pad level

Behaviour:
- Reset values: state IDLE, sccb_scl_oe=0, sccb_sda_oe=0, done=0, nack=0, divider=0, bit counter=0.
- Reset acts immediately and asynchronously; a transfer in progress is abandoned and both lines are released.
- ready = (state==IDLE) & ~start, combinational.
  - It falls in the start cycle itself, so an upstream "rdreq = ~empty & ready; start = rdreq delayed 1" pipeline cannot issue a second read while a command is being taken.
- A start with state!=IDLE is ignored and no command is latched.
- On an accepted start:
  - Shift register loads {DEV_ADDR, address[15:8], address[7:0], data}, 32 bits, MSB first.
  - Divider clears. The next cycle enters START.
- Quarter tick: divider counts 0..QTR_DIV-1 and ticks at QTR_DIV-1. It runs only when state != IDLE.
- START, 2 quarters:
  - q0: sda_oe=1, scl_oe=0, i.e. SDA falls while SCL is high.
  - q1: scl_oe=1.
- BIT, 36 bit slots (4 bytes x 9), each 4 quarters:
  - q0: scl_oe=1. SDA is updated at q0 entry:
    - data bits: sda_oe = ~bit;
    - ninth bit: sda_oe = 0 (released).
  - q1: scl_oe=1.
  - q2, q3: scl_oe=0.
  - Ninth bit: sccb_sda_in is sampled on the last cycle of q2. A 1 sets an internal nack flag.
- STOP, 3 quarters:
  - q0: scl_oe=1, sda_oe=1.
  - q1: scl_oe=0, sda_oe=1.
  - q2: sda_oe=0, so SDA rises while SCL is high.
- GAP, 4 quarters: both lines released (bus-free time).
  - On the final tick: state goes to IDLE, done=1 for one cycle, nack takes the internal flag, and the flag clears.
- Total latency from the start cycle to the done pulse is exactly (2+144+3+4)*QTR_DIV + 1 cycles. With defaults that is 153*125 + 1 = 19126.
- Clock stretching is not supported; SCL is never read back.
- Bit counter is 6 bits, 0..35.
  - Byte boundary when bit_in_byte == 8 (ninth bit).
  - Shift register shifts only on data bits, never on ninth bits.
- done and an upstream start may coincide with ready: the following cycle ready=1, so a start there is accepted with no dead cycle.

Decomposition:
- Package sccb_pkg:
  - state enum: IDLE, START, BIT, STOP, GAP;
  - localparams: BITS_PER_BYTE_SLOT=9, NUM_BYTES=4, START_QTRS=2, STOP_QTRS=3, GAP_QTRS=4;
  - default DEV_ADDR.
- One sub-module, sccb_qtr_tick:
  - parameterised divider with enable and synchronous clear;
  - outputs a one-cycle tick and a 2-bit quarter index.
- sccb_write_master holds the FSM, shift register, bit counter, SDA synchroniser and nack logic.

Test Plan:
- QTR_DIV=2; start with address=16'h3008, data=8'h82; open-drain model with pull-up and a slave always ACKing (drives low).
  - SDA bytes decoded on SCL rising edges = 78,30,08,82.
  - START/STOP conditions are seen.
  - done arrives exactly 307 cycles after start, with nack=0.
- Same transfer with the slave releasing SDA on the third ninth bit -> nack=1 with done. A following clean transfer returns nack=0.
- Upstream FIFO model: pre-load 3 commands, rdreq=~empty&ready, start=rdreq registered.
  - Exactly 3 transfers, in order, with no duplicates or losses.
  - ready is low in every start cycle.
- start pulsed during BIT and during GAP -> ignored; the bus waveform is identical to a single transfer, and only one done occurs.
- reset_n asserted mid-byte 2 -> scl_oe=sda_oe=0 and ready=1 without waiting for a clock edge.
  - After release, a new command 16'h3103/8'h11 completes normally.
- Default parameters: measure the SCL period = 500 cycles (100 kHz @ 50 MHz) and start-to-done = 19126 cycles.

Source files
------------

// File: rtl/sccb_pkg.sv
// Shared constants for the SCCB write master: FSM encodings, frame geometry
// and the default OV5640 write ID.
package sccb_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_BIT   = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;

  localparam int BITS_PER_BYTE_SLOT = 9;
  localparam int NUM_BYTES          = 4;
  localparam int NUM_SLOTS          = BITS_PER_BYTE_SLOT * NUM_BYTES;
  localparam int START_QTRS         = 2;
  localparam int BIT_QTRS           = 4;
  localparam int STOP_QTRS          = 3;
  localparam int GAP_QTRS           = 4;

  localparam logic [7:0] DEFAULT_DEV_ADDR = 8'h78;

  // Index of the final quarter of each bus phase.
  function automatic logic [1:0] last_qtr(input logic [2:0] st);
    case (st)
      ST_START: last_qtr = 2'(START_QTRS - 1);
      ST_BIT:   last_qtr = 2'(BIT_QTRS - 1);
      ST_STOP:  last_qtr = 2'(STOP_QTRS - 1);
      ST_GAP:   last_qtr = 2'(GAP_QTRS - 1);
      default:  last_qtr = 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/sccb_qtr_tick.sv
// Quarter-period timebase: divides clk_sys by QTR_DIV and tracks which quarter
// of the current bus phase is active.
module sccb_qtr_tick #(
  parameter int QTR_DIV = 125
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       en_i,
  input  logic       clr_i,
  output logic       tick_o,
  output logic [1:0] qtr_o
);

  localparam int CW = (QTR_DIV > 1) ? $clog2(QTR_DIV) : 1;

  logic [CW-1:0] div_q, div_d;
  logic [1:0]    qtr_q, qtr_d;

  assign tick_o = en_i & (div_q == CW'(QTR_DIV - 1));
  assign qtr_o  = qtr_q;

  // Clear wins over tick so a phase change restarts both divider and quarter.
  always_comb begin
    div_d = div_q;
    qtr_d = qtr_q;
    if (clr_i) begin
      div_d = '0;
      qtr_d = '0;
    end else if (tick_o) begin
      div_d = '0;
      qtr_d = qtr_q + 2'd1;
    end else if (en_i) begin
      div_d = div_q + CW'(1);
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      div_q <= '0;
      qtr_q <= '0;
    end else begin
      div_q <= div_d;
      qtr_q <= qtr_d;
    end
  end

endmodule

// File: rtl/sccb_write_master.sv
// SCCB 3-phase write master: one start strobe sends {ID, addr hi, addr lo, data}
// on open-drain SCL/SDA (oe=1 pulls the line low), then reports done/nack.
module sccb_write_master
  import sccb_pkg::*;
#(
  parameter int         CLK_FREQ_HZ = 50_000_000,
  parameter int         SCL_FREQ_HZ = 100_000,
  parameter logic [7:0] DEV_ADDR    = DEFAULT_DEV_ADDR,
  parameter int         QTR_DIV     = CLK_FREQ_HZ / (4 * SCL_FREQ_HZ)
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] address,
  input  logic [7:0]  data,
  output logic        ready,
  output logic        done,
  output logic        nack,
  output logic        sccb_scl_oe,
  output logic        sccb_sda_oe,
  input  logic        sccb_sda_in
);

  logic [2:0]  state_q, state_d;
  logic [31:0] shreg_q, shreg_d;
  logic [5:0]  bit_q, bit_d;
  logic [3:0]  bib_q, bib_d;
  logic        scl_q, scl_d, sda_q, sda_d;
  logic        done_q, done_d;
  logic        nack_q, nack_d;
  logic        flag_q, flag_d;
  logic [1:0]  sync_q;
  logic        tick, accept, at_last, qclr, ninth;
  logic [1:0]  qtr, qtr_n;

  // Pin drive for a given phase/quarter, returned as {scl_oe, sda_oe}.
  function automatic logic [1:0] pins(input logic [2:0] st, input logic [1:0] q,
                                      input logic nb, input logic b);
    case (st)
      ST_START: pins = {q == 2'd1, 1'b1};
      ST_BIT:   pins = {q < 2'd2, ~nb & ~b};
      ST_STOP:  pins = {q == 2'd0, q != 2'd2};
      default:  pins = 2'b00;
    endcase
  endfunction

  sccb_qtr_tick #(.QTR_DIV(QTR_DIV)) u_tick (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .en_i    (state_q != ST_IDLE),
    .clr_i   (qclr),
    .tick_o  (tick),
    .qtr_o   (qtr)
  );

  assign accept  = start & (state_q == ST_IDLE);
  assign at_last = (qtr == last_qtr(state_q));
  assign qclr    = accept | (tick & at_last);
  assign qtr_n   = (tick & ~at_last) ? qtr + 2'd1 : 2'd0;
  assign ninth   = (bib_q == 4'(BITS_PER_BYTE_SLOT - 1));

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bit_d   = bit_q;
    bib_d   = bib_q;
    flag_d  = flag_q;
    nack_d  = nack_q;
    done_d  = 1'b0;
    scl_d   = scl_q;
    sda_d   = sda_q;
    if (accept) begin
      state_d = ST_START;
      shreg_d = {DEV_ADDR, address, data};
      bit_d   = '0;
      bib_d   = '0;
    end else if (tick) begin
      case (state_q)
        ST_START: if (at_last) begin
          state_d = ST_BIT;
          bit_d   = '0;
          bib_d   = '0;
        end
        ST_BIT: begin
          if (ninth && qtr == 2'd2 && sync_q[1])
            flag_d = 1'b1;
          if (at_last) begin
            // Ninth bits carry no payload, so the shifter holds across them.
            if (!ninth)
              shreg_d = {shreg_q[30:0], 1'b0};
            if (bit_q == 6'(NUM_SLOTS - 1)) begin
              state_d = ST_STOP;
            end else begin
              bit_d = bit_q + 6'd1;
              bib_d = ninth ? 4'd0 : bib_q + 4'd1;
            end
          end
        end
        ST_STOP: if (at_last) state_d = ST_GAP;
        ST_GAP: if (at_last) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          nack_d  = flag_q;
          flag_d  = 1'b0;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    if (accept | tick)
      {scl_d, sda_d} = pins(state_d, qtr_n, bib_d == 4'(BITS_PER_BYTE_SLOT - 1), shreg_d[31]);
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      bit_q   <= '0;
      bib_q   <= '0;
      flag_q  <= 1'b0;
      nack_q  <= 1'b0;
      done_q  <= 1'b0;
      scl_q   <= 1'b0;
      sda_q   <= 1'b0;
      sync_q  <= 2'b11;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bit_q   <= bit_d;
      bib_q   <= bib_d;
      flag_q  <= flag_d;
      nack_q  <= nack_d;
      done_q  <= done_d;
      scl_q   <= scl_d;
      sda_q   <= sda_d;
      sync_q  <= {sync_q[0], sccb_sda_in};
    end
  end

  assign ready       = (state_q == ST_IDLE) & ~start;
  assign done        = done_q;
  assign nack        = nack_q;
  assign sccb_scl_oe = scl_q;
  assign sccb_sda_oe = sda_q;

endmodule

// File: tb/tb_sccb_write_master.sv
// Bench for sccb_write_master: open-drain bus with pull-ups, an ACKing slave
// that decodes bytes, and a command scoreboard checked on every done pulse.
module tb_sccb_write_master;

  localparam int Q   = 2;
  localparam int LAT = 153 * Q + 1;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
    logic        nk;
    int          t0;
  } exp_t;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        start   = 1'b0;
  logic        start2  = 1'b0;
  logic [15:0] address = '0;
  logic [7:0]  data    = '0;
  logic        ready, done, nack, scl_oe, sda_oe;
  logic        ready2, done2, nack2, scl2_oe, sda2_oe;
  logic        scl, sda, sda2;
  logic        slave_drv = 1'b0;
  logic [3:0]  nack_mask = '0;

  assign scl  = ~scl_oe;
  assign sda  = ~(sda_oe | slave_drv);
  assign sda2 = ~sda2_oe;

  sccb_write_master #(.QTR_DIV(Q)) u_dut (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .start       (start),
    .address     (address),
    .data        (data),
    .ready       (ready),
    .done        (done),
    .nack        (nack),
    .sccb_scl_oe (scl_oe),
    .sccb_sda_oe (sda_oe),
    .sccb_sda_in (sda)
  );

  sccb_write_master u_def (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .start       (start2),
    .address     (address),
    .data        (data),
    .ready       (ready2),
    .done        (done2),
    .nack        (nack2),
    .sccb_scl_oe (scl2_oe),
    .sccb_sda_oe (sda2_oe),
    .sccb_sda_in (sda2)
  );

  always #5 clk_sys = ~clk_sys;

  int   total = 0, bad = 0, cyc = 0, ndone = 0;
  int   n_start = 0, n_stop = 0, bitpos = 0, byteidx = 0;
  int   tr_base = 0, diffs = 0, n0 = 0, t0d = 0, tdone = 0;
  logic tr_on = 1'b0, got = 1'b0, rd_r = 1'b0;
  logic [7:0]  shb = '0;
  logic [7:0]  gb [4];
  logic [23:0] hold = '0;
  int   trace[$], ref_tr[$], d_rise[$];
  exp_t sb[$];
  logic [23:0] cmdq[$];

  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [15:0] a, input logic [7:0] d, input logic nk);
    exp_t e;
    chk("ready_idle", 32'(ready), 32'(1));
    e.a = a; e.d = d; e.nk = nk; e.t0 = cyc;
    sb.push_back(e);
    start = 1'b1; address = a; data = d; tr_base = cyc;
    #1 chk("ready_in_start", 32'(ready), 32'(0));
    @(negedge clk_sys);
    start = 1'b0;
  endtask

  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    start = 1'b1; address = a; data = d;
    #1 chk("ready_busy", 32'(ready), 32'(0));
    @(negedge clk_sys);
    start = 1'b0;
  endtask

  task automatic wait_done(input int lim);
    int k;
    k = ndone;
    for (int i = 0; i < lim && ndone == k; i++) @(negedge clk_sys);
    chk("done_timeout", 32'(ndone != k), 32'(1));
  endtask

  // Bus monitor and slave: everything sampled on the falling clock edge.
  initial begin : bus_mon
    exp_t e;
    logic prev_scl, prev_sda;
    prev_scl = 1'b1;
    prev_sda = 1'b1;
    forever begin
      @(negedge clk_sys);
      if (prev_scl && scl && prev_sda && !sda) begin
        n_start++; bitpos = 0; byteidx = 0; slave_drv = 1'b0;
        for (int i = 0; i < 4; i++) gb[i] = 8'h00;
      end
      if (prev_scl && scl && !prev_sda && sda) n_stop++;
      if (!prev_scl && scl) begin
        if (bitpos < 8) shb = {shb[6:0], sda};
        bitpos++;
        if (bitpos == 8 && byteidx < 4) gb[byteidx] = shb;
        if (bitpos == 9) begin bitpos = 0; byteidx++; end
      end
      if (prev_scl && !scl) begin
        slave_drv = 1'b0;
        if (bitpos == 8 && byteidx < 4) slave_drv = ~nack_mask[byteidx];
      end
      if (tr_on && (scl !== prev_scl || sda !== prev_sda))
        trace.push_back(((cyc - tr_base) << 2) | int'({scl, sda}));
      if (done) begin
        ndone++;
        chk("sb_level", 32'(sb.size() != 0), 32'(1));
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("bytes", {gb[0], gb[1], gb[2], gb[3]}, {8'h78, e.a, e.d});
          chk("nack", 32'(nack), 32'(e.nk));
          chk("latency", cyc - e.t0, LAT);
          chk("start_cond", n_start, 1);
          chk("stop_cond", n_stop, 1);
        end
        n_start = 0; n_stop = 0;
      end
      prev_scl = scl;
      prev_sda = sda;
    end
  end

  initial begin : def_mon
    logic p2;
    p2 = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (scl2_oe && !p2) d_rise.push_back(cyc);
      p2 = scl2_oe;
    end
  end

  initial begin
    repeat (3) @(negedge clk_sys);
    chk("rst_scl_oe", 32'(scl_oe), 32'(0));
    chk("rst_sda_oe", 32'(sda_oe), 32'(0));
    chk("rst_done",   32'(done),   32'(0));
    chk("rst_nack",   32'(nack),   32'(0));
    chk("rst_ready",  32'(ready),  32'(1));
    reset_n = 1'b1;
    repeat (2) @(negedge clk_sys);

    // Clean transfer, kept as the reference waveform
    tr_on = 1'b1;
    issue(16'h3008, 8'h82, 1'b0);
    wait_done(LAT + 50);
    tr_on = 1'b0;
    ref_tr = trace;
    trace.delete();
    repeat (2) @(negedge clk_sys);

    // NACK on the third ninth bit, then a clean one
    nack_mask = 4'b0100;
    issue(16'h3008, 8'h82, 1'b1);
    wait_done(LAT + 50);
    nack_mask = 4'b0000;
    repeat (2) @(negedge clk_sys);
    issue(16'h3008, 8'h82, 1'b0);
    wait_done(LAT + 50);
    repeat (2) @(negedge clk_sys);

    // Upstream FIFO: rdreq = ~empty & ready, start = rdreq registered
    cmdq.push_back({16'h3103, 8'h11});
    cmdq.push_back({16'h4300, 8'h30});
    cmdq.push_back({16'h0000, 8'hFF});
    n0 = ndone;
    rd_r = 1'b0;
    for (int i = 0; i < 4000 && ndone - n0 < 3; i++) begin
      exp_t e;
      start = rd_r;
      if (rd_r) begin
        address = hold[23:8]; data = hold[7:0];
        e.a = hold[23:8]; e.d = hold[7:0]; e.nk = 1'b0; e.t0 = cyc;
        sb.push_back(e);
      end
      #1;
      if (start) chk("fifo_ready_in_start", 32'(ready), 32'(0));
      rd_r = (cmdq.size() != 0) && ready;
      if (rd_r) hold = cmdq.pop_front();
      @(negedge clk_sys);
    end
    start = 1'b0;
    repeat (20) @(negedge clk_sys);
    chk("fifo_dones", ndone - n0, 3);
    chk("fifo_drained", cmdq.size(), 0);
    chk("fifo_sb_empty", sb.size(), 0);

    // Starts during BIT and GAP must be ignored
    n0 = ndone;
    tr_on = 1'b1;
    issue(16'h3008, 8'h82, 1'b0);
    repeat (85) @(negedge clk_sys);
    poke(16'hFFFF, 8'h00);
    repeat (214) @(negedge clk_sys);
    poke(16'h1234, 8'h56);
    wait_done(LAT + 50);
    tr_on = 1'b0;
    repeat (20) @(negedge clk_sys);
    chk("single_done", ndone - n0, 1);
    chk("trace_len", trace.size(), ref_tr.size());
    diffs = 0;
    for (int i = 0; i < trace.size() && i < ref_tr.size(); i++)
      if (trace[i] != ref_tr[i]) diffs++;
    chk("waveform", diffs, 0);
    trace.delete();

    // Asynchronous reset in the middle of the address-high byte
    issue(16'h3008, 8'h82, 1'b0);
    repeat (109) @(negedge clk_sys);
    chk("pre_rst_scl_oe", 32'(scl_oe), 32'(1));
    chk("pre_rst_sda_oe", 32'(sda_oe), 32'(1));
    #2 reset_n = 1'b0;
    #1;
    chk("arst_scl_oe", 32'(scl_oe), 32'(0));
    chk("arst_sda_oe", 32'(sda_oe), 32'(0));
    chk("arst_ready",  32'(ready),  32'(1));
    void'(sb.pop_back());
    repeat (3) @(negedge clk_sys);
    reset_n = 1'b1;
    n_start = 0; n_stop = 0;
    repeat (2) @(negedge clk_sys);
    issue(16'h3103, 8'h11, 1'b0);
    wait_done(LAT + 50);
    repeat (2) @(negedge clk_sys);
    chk("sb_drained", sb.size(), 0);

    // Default parameters: 50 MHz / 100 kHz, no slave on the bus
    chk("def_ready", 32'(ready2), 32'(1));
    d_rise.delete();
    address = 16'h3008; data = 8'h82;
    start2 = 1'b1; t0d = cyc;
    @(negedge clk_sys);
    start2 = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 21000 && !got; i++) begin
      @(negedge clk_sys);
      if (done2) begin got = 1'b1; tdone = cyc; end
    end
    chk("def_done_seen", 32'(got), 32'(1));
    if (got) begin
      chk("def_latency", tdone - t0d, 19126);
      chk("def_nack", 32'(nack2), 32'(1));
    end
    chk("def_rises", 32'(d_rise.size() >= 3), 32'(1));
    if (d_rise.size() >= 3) chk("def_scl_period", d_rise[2] - d_rise[1], 500);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
